// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
package cpu_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_BUSY_IF = 3'd1,
    ST_BUSY_DM = 3'd2,
    ST_DONE_IF = 3'd3,
    ST_DONE_DM = 3'd4
  } arb_state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } gnt_e;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and backing-memory signals seen by the arbiter.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic [DATA_W-1:0] if_data_o;
  logic              if_ack_o;
  logic              dm_req_i;
  logic              dm_we_i;
  logic [ADDR_W-1:0] dm_addr_i;
  logic [DATA_W-1:0] dm_wdata_i;
  logic [DATA_W-1:0] dm_rdata_o;
  logic              dm_ack_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_ack_i;
  logic              stall_o;
  logic              err_o;

  // Arbiter side
  modport master (
    input  if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
           mem_rdata_i, mem_ack_i,
    output if_data_o, if_ack_o, dm_rdata_o, dm_ack_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_o, err_o
  );

  // Requesters and memory side
  modport slave (
    output if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
           mem_rdata_i, mem_ack_i,
    input  if_data_o, if_ack_o, dm_rdata_o, dm_ack_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_o, err_o
  );
endinterface

// File: rtl/arb_timeout_counter.sv
// Busy-cycle counter; term_o flags the last cycle allowed before abort.
module arb_timeout_counter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic term_o
);
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign term_o = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                 cnt_d = '0;
    else if (en_i && !term_o)  cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between fetch and load/store, with
// starvation guard for fetch, busy timeout and pipeline stall.
module mem_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       STARVE_MAX = 4,
  parameter int unsigned       TIMEOUT    = 16,
  parameter logic [DATA_W-1:0] ERR_DATA   = DATA_W'(ERR_DATA_DEFAULT)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  mem_arbiter_if.master bus
);
  localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

  arb_state_e        state_q, state_d;
  logic [STV_W-1:0]  starve_q, starve_d;
  logic              mask_if_q, mask_if_d, mask_dm_q, mask_dm_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_ack_q, if_ack_d, dm_ack_q, dm_ack_d;
  logic [DATA_W-1:0] if_data_q, if_data_d, dm_rdata_q, dm_rdata_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] resp_data;
  logic              tmo_clr, tmo_en, tmo_term, starve_at_max;
  gnt_e              gnt_sel;

  arb_timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (tmo_clr),
    .en_i   (tmo_en),
    .term_o (tmo_term)
  );

  assign starve_at_max = (starve_q == STV_W'(STARVE_MAX));
  assign gnt_sel = (bus.if_req_i && (!bus.dm_req_i || starve_at_max)) ? GNT_IF : GNT_DM;

  // A masked winner (just served) waits a cycle rather than handing the slot away,
  // so a continuously requesting DM side still exercises the starvation guard.
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    mask_if_d   = (state_q == ST_DONE_IF);
    mask_dm_d   = (state_q == ST_DONE_DM);
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    if_data_d   = if_data_q;
    dm_rdata_d  = dm_rdata_q;
    err_d       = err_q;
    resp_data   = bus.mem_ack_i ? bus.mem_rdata_i : ERR_DATA;
    tmo_clr     = 1'b0;
    tmo_en      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (gnt_sel == GNT_IF && bus.if_req_i && !mask_if_q) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = bus.if_addr_i;
          starve_d   = '0;
          tmo_clr    = 1'b1;
          state_d    = ST_BUSY_IF;
        end else if (gnt_sel == GNT_DM && bus.dm_req_i && !mask_dm_q) begin
          mem_req_d   = 1'b1;
          mem_we_d    = bus.dm_we_i;
          mem_addr_d  = bus.dm_addr_i;
          mem_wdata_d = bus.dm_wdata_i;
          if (bus.if_req_i && !starve_at_max) starve_d = starve_q + STV_W'(1);
          tmo_clr     = 1'b1;
          state_d     = ST_BUSY_DM;
        end
      end
      ST_BUSY_IF, ST_BUSY_DM: begin
        tmo_en = 1'b1;
        if (bus.mem_ack_i || tmo_term) begin
          mem_req_d = 1'b0;
          tmo_clr   = 1'b1;
          err_d     = err_q | ~bus.mem_ack_i;
          if (state_q == ST_BUSY_IF) begin
            if_data_d = resp_data;
            if_ack_d  = 1'b1;
            state_d   = ST_DONE_IF;
          end else begin
            dm_rdata_d = resp_data;
            dm_ack_d   = 1'b1;
            state_d    = ST_DONE_DM;
          end
        end
      end
      ST_DONE_IF, ST_DONE_DM: state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      starve_q    <= '0;
      mask_if_q   <= 1'b0;
      mask_dm_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_data_q   <= '0;
      dm_rdata_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      mask_if_q   <= mask_if_d;
      mask_dm_q   <= mask_dm_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      if_data_q   <= if_data_d;
      dm_rdata_q  <= dm_rdata_d;
      err_q       <= err_d;
    end
  end

  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
  assign bus.if_ack_o    = if_ack_q;
  assign bus.dm_ack_o    = dm_ack_q;
  assign bus.if_data_o   = if_data_q;
  assign bus.dm_rdata_o  = dm_rdata_q;
  assign bus.err_o       = err_q;
  assign bus.stall_o     = (bus.if_req_i & ~if_ack_q) | (bus.dm_req_i & ~dm_ack_q);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural backing-memory responder.
module tb_mem_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(4), .TIMEOUT(16), .ERR_DATA(32'hDEADBEEF)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // memory model and responder state
  logic [31:0] mem_m [logic [31:0]];
  logic [31:0] log_q [$];
  int          ack_delay = 0;
  bit          mem_dead  = 1'b0;
  int          wait_cnt  = 0;
  int          stable_err = 0;
  logic [31:0] seen_addr, seen_wdata;
  logic        seen_we;

  typedef struct {
    bit          is_dm;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] log_at(input int i);
    if (i < log_q.size()) return log_q[i];
    return 32'hFFFF_FFFF;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Backing memory: ack ack_delay cycles after mem_req_o rises, check stability meanwhile
  initial begin
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_ack_i = 1'b0;
      if (!bus.mem_req_o) begin
        wait_cnt = 0;
      end else begin
        if (wait_cnt == 0) begin
          seen_addr  = bus.mem_addr_o;
          seen_we    = bus.mem_we_o;
          seen_wdata = bus.mem_wdata_o;
        end else if (bus.mem_addr_o !== seen_addr || bus.mem_we_o !== seen_we ||
                     bus.mem_wdata_o !== seen_wdata) begin
          stable_err++;
        end
        if (!mem_dead && wait_cnt == ack_delay) begin
          bus.mem_ack_i = 1'b1;
          if (bus.mem_we_o) mem_m[bus.mem_addr_o] = bus.mem_wdata_o;
          else              bus.mem_rdata_i = model_rd(bus.mem_addr_o);
          log_q.push_back(bus.mem_addr_o);
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  task automatic run_txn(input bit is_dm, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input int delay,
                         output int lat, output logic [31:0] data,
                         output bit stall_ok, output bit one_pulse);
    ack_delay = delay;
    stall_ok  = 1'b1;
    lat       = -1;
    data      = '0;
    if (is_dm) begin
      bus.dm_req_i = 1'b1; bus.dm_we_i = we; bus.dm_addr_i = addr; bus.dm_wdata_i = wdata;
    end else begin
      bus.if_req_i = 1'b1; bus.if_addr_i = addr;
    end
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      step();
      if (is_dm ? bus.dm_ack_o : bus.if_ack_o) begin
        lat  = c;
        data = is_dm ? bus.dm_rdata_o : bus.if_data_o;
        if (bus.stall_o !== 1'b0) stall_ok = 1'b0;
      end else if (bus.stall_o !== 1'b1) begin
        stall_ok = 1'b0;
      end
    end
    bus.if_req_i = 1'b0;
    bus.dm_req_i = 1'b0;
    bus.dm_we_i  = 1'b0;
    step();
    one_pulse = !(bus.if_ack_o || bus.dm_ack_o);
    step();
  endtask

  initial begin
    int          lat;
    logic [31:0] data;
    bit          stall_ok, one_pulse, got_if, got_dm;
    logic [31:0] if_d, dm_d;
    int          n_dm, if_acks;
    logic [31:0] exp_log [10];

    rst = 1'b1;
    bus.if_req_i = 0; bus.if_addr_i = '0;
    bus.dm_req_i = 0; bus.dm_we_i = 0; bus.dm_addr_i = '0; bus.dm_wdata_i = '0;
    mem_m[32'h40]  = 32'h2002_0005;
    mem_m[32'h100] = 32'h1111_0100;

    vecs[0] = '{1'b0, 1'b0, 32'h40,  32'h0,         2,  32'h2002_0005, 4};
    vecs[1] = '{1'b1, 1'b0, 32'h100, 32'h0,         0,  32'h1111_0100, 2};
    vecs[2] = '{1'b1, 1'b1, 32'h20,  32'hCAFE_F00D, 1,  32'h0,         3};
    vecs[3] = '{1'b1, 1'b0, 32'h20,  32'h0,         3,  32'hCAFE_F00D, 5};
    vecs[4] = '{1'b0, 1'b0, 32'h44,  32'h0,         0,  32'hA5A5_0044, 2};
    vecs[5] = '{1'b0, 1'b0, 32'h48,  32'h0,         15, 32'hA5A5_0048, 17};
    vecs[6] = '{1'b1, 1'b0, 32'h104, 32'h0,         14, 32'hA5A5_0104, 16};

    step(); step();
    check("rst_mem_req",  32'(bus.mem_req_o), 32'd0);
    check("rst_mem_we",   32'(bus.mem_we_o),  32'd0);
    check("rst_mem_addr", bus.mem_addr_o,     32'd0);
    check("rst_if_ack",   32'(bus.if_ack_o),  32'd0);
    check("rst_dm_ack",   32'(bus.dm_ack_o),  32'd0);
    check("rst_if_data",  bus.if_data_o,      32'd0);
    check("rst_dm_rdata", bus.dm_rdata_o,     32'd0);
    check("rst_err",      32'(bus.err_o),     32'd0);
    check("rst_stall",    32'(bus.stall_o),   32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i].is_dm, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].delay,
              lat, data, stall_ok, one_pulse);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      if (!vecs[i].we) check($sformatf("v%0d_data", i), data, vecs[i].exp_data);
      check($sformatf("v%0d_mem_addr", i), seen_addr, vecs[i].addr);
      check($sformatf("v%0d_mem_we", i), 32'(seen_we), 32'(vecs[i].we));
      if (vecs[i].we) check($sformatf("v%0d_mem_wdata", i), seen_wdata, vecs[i].wdata);
      check($sformatf("v%0d_stall", i), 32'(stall_ok), 32'd1);
      check($sformatf("v%0d_one_pulse", i), 32'(one_pulse), 32'd1);
      check($sformatf("v%0d_err", i), 32'(bus.err_o), 32'd0);
    end

    // Simultaneous requests: DM first, then IF
    log_q.delete();
    ack_delay = 1;
    got_if = 0; got_dm = 0; if_d = '0; dm_d = '0;
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h80;
    bus.dm_req_i = 1'b1; bus.dm_we_i = 1'b0; bus.dm_addr_i = 32'h100;
    for (int c = 0; c < 40 && !(got_if && got_dm); c++) begin
      step();
      if (bus.if_ack_o) begin if_d = bus.if_data_o; got_if = 1'b1; bus.if_req_i = 1'b0; end
      if (bus.dm_ack_o) begin dm_d = bus.dm_rdata_o; got_dm = 1'b1; bus.dm_req_i = 1'b0; end
    end
    check("both_acked", 32'(got_if && got_dm), 32'd1);
    check("both_first_addr", log_at(0), 32'h100);
    check("both_second_addr", log_at(1), 32'h80);
    check("both_dm_data", dm_d, 32'h1111_0100);
    check("both_if_data", if_d, 32'hA5A5_0080);
    step(); step();

    // Starvation guard: DM held continuously, IF forced every 5th grant
    log_q.delete();
    ack_delay = 0;
    n_dm = 0; if_acks = 0;
    exp_log = '{32'h300, 32'h304, 32'h308, 32'h30C, 32'h200,
                32'h310, 32'h314, 32'h318, 32'h31C, 32'h204};
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h200;
    bus.dm_req_i = 1'b1; bus.dm_we_i = 1'b0; bus.dm_addr_i = 32'h300;
    for (int c = 0; c < 300 && if_acks < 2; c++) begin
      step();
      if (bus.dm_ack_o) begin n_dm++; bus.dm_addr_i = 32'h300 + 32'(4 * n_dm); end
      if (bus.if_ack_o) begin if_acks++; bus.if_addr_i = 32'h204; end
    end
    bus.if_req_i = 1'b0;
    bus.dm_req_i = 1'b0;
    check("starve_if_acks", 32'(if_acks), 32'd2);
    check("starve_dm_acks", 32'(n_dm), 32'd8);
    for (int i = 0; i < 10; i++) check($sformatf("starve_grant%0d", i), log_at(i), exp_log[i]);
    step(); step();

    // Timeout: no memory ack
    mem_dead = 1'b1;
    run_txn(1'b0, 1'b0, 32'h60, 32'h0, 0, lat, data, stall_ok, one_pulse);
    check("tmo_latency", 32'(lat), 32'd17);
    check("tmo_data", data, 32'hDEAD_BEEF);
    check("tmo_err", 32'(bus.err_o), 32'd1);
    mem_dead = 1'b0;
    run_txn(1'b1, 1'b0, 32'h100, 32'h0, 1, lat, data, stall_ok, one_pulse);
    check("post_tmo_data", data, 32'h1111_0100);
    check("post_tmo_latency", 32'(lat), 32'd3);
    check("err_sticky", 32'(bus.err_o), 32'd1);

    // Reset during BUSY_DM
    mem_dead = 1'b1;
    bus.dm_req_i = 1'b1; bus.dm_we_i = 1'b0; bus.dm_addr_i = 32'h100;
    step(); step(); step();
    check("busy_before_rst", 32'(bus.mem_req_o), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_async_mem_req", 32'(bus.mem_req_o), 32'd0);
    check("rst_async_dm_ack", 32'(bus.dm_ack_o), 32'd0);
    step();
    check("rst_hold_dm_ack", 32'(bus.dm_ack_o), 32'd0);
    check("rst_clears_err", 32'(bus.err_o), 32'd0);
    mem_dead  = 1'b0;
    ack_delay = 0;
    rst = 1'b0;
    lat = -1;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      step();
      if (bus.dm_ack_o) begin lat = c; data = bus.dm_rdata_o; end
    end
    bus.dm_req_i = 1'b0;
    check("reserve_latency", 32'(lat), 32'd2);
    check("reserve_data", data, 32'h1111_0100);
    step(); step();

    check("mem_outputs_stable", 32'(stable_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
